// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID check sequencer: FSM states, word indices, default expected words.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CMP,
    DONE
  } sid_state_e;

  localparam logic SID_WORD_ID = 1'b0;
  localparam logic SID_WORD_TS = 1'b1;

  localparam logic [31:0] SID_DEFAULT_ID = 32'hACD5_1302;
  localparam logic [31:0] SID_DEFAULT_TS = 32'h54AC_5DC8;

  // States in which the sequencer owns the slave and stalls the external port.
  function automatic logic sid_is_busy(input sid_state_e s);
    return (s == RD_ID) || (s == RD_TS) || (s == CMP);
  endfunction

endpackage

// File: rtl/sysid_ext_port.sv
// External read return path: registers slave data for an accepted read and pulses readdatavalid.
// Latency: 1 cycle from acceptance to readdatavalid; one read per cycle.
// Backpressure: none here; the parent withholds accept while the slave is busy.
// Ports: accept_i (read accepted this cycle), sid_readdata_i (slave data for the
//        external address), readdata_o / readdatavalid_o (registered response).
module sysid_ext_port (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        accept_i,
  input  logic [31:0] sid_readdata_i,
  output logic [31:0] readdata_o,
  output logic        readdatavalid_o
);

  logic [31:0] readdata_q, readdata_d;
  logic        readdatavalid_q, readdatavalid_d;

  always_comb begin
    readdata_d      = readdata_q;
    readdatavalid_d = accept_i;
    if (accept_i) begin
      readdata_d = sid_readdata_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  assign readdata_o      = readdata_q;
  assign readdatavalid_o = readdatavalid_q;

endmodule

// File: rtl/sysid_check_ctrl.sv
// System-ID check sequencer: reads ID and timestamp words, compares, retries, and arbitrates the slave with one external reader.
// Latency: start to check_done 4 cycles (+3 per retry); external read data 1 cycle after acceptance.
// Backpressure: ext_waitrequest is raised combinationally for ext_read while a check owns the slave.
// Ports: clock/reset_n; start; ext_* (Avalon-MM read slave); sid_address/sid_readdata
//        (slave side); busy, check_done, check_pass, id_word, ts_word, retry_cnt (status).
module sysid_check_ctrl
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = SID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS = SID_DEFAULT_TS,
  parameter int unsigned MAX_RETRIES = 2,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        ext_read,
  input  logic        ext_address,
  output logic        ext_waitrequest,
  output logic [31:0] ext_readdata,
  output logic        ext_readdatavalid,
  output logic        sid_address,
  input  logic [31:0] sid_readdata,
  output logic        busy,
  output logic        check_done,
  output logic        check_pass,
  output logic [31:0] id_word,
  output logic [31:0] ts_word,
  output logic [3:0]  retry_cnt
);

  localparam logic [3:0] MAX_RETRY = 4'(MAX_RETRIES);

  sid_state_e  state_q, state_d;
  logic        pending_q, pending_d;
  logic        auto_q;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic [3:0]  retry_q, retry_d;

  logic        own_slave;
  logic        ext_accept;
  logic        start_req;

  assign own_slave       = sid_is_busy(state_q);
  assign ext_waitrequest = own_slave & ext_read;
  assign ext_accept      = ext_read & ~own_slave;

  // auto_q acts as a start pulse during the first cycle after reset release.
  assign start_req = start | auto_q;

  always_comb begin
    sid_address = ext_address;
    case (state_q)
      RD_ID:    sid_address = SID_WORD_ID;
      RD_TS,
      CMP:      sid_address = SID_WORD_TS;
      default:  sid_address = ext_address;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    done_d    = done_q;
    pass_d    = pass_q;
    id_d      = id_q;
    ts_d      = ts_q;
    retry_d   = retry_q;
    case (state_q)
      IDLE, DONE: begin
        // A start always passes through the pending latch, so the external
        // port keeps the slave for the cycle in which start is sampled.
        if (pending_q) begin
          state_d   = RD_ID;
          pending_d = 1'b0;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          retry_d   = '0;
        end else if (start_req) begin
          pending_d = 1'b1;
        end
      end
      RD_ID: begin
        id_d    = sid_readdata;
        state_d = RD_TS;
      end
      RD_TS: begin
        ts_d    = sid_readdata;
        state_d = CMP;
      end
      CMP: begin
        if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS)) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (retry_q < MAX_RETRY) begin
          retry_d = retry_q + 4'd1;
          state_d = RD_ID;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = sid_is_busy(state_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      auto_q    <= AUTO_START;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      id_q      <= '0;
      ts_q      <= '0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      auto_q    <= 1'b0;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      id_q      <= id_d;
      ts_q      <= ts_d;
      retry_q   <= retry_d;
    end
  end

  sysid_ext_port u_ext_port (
    .clock           (clock),
    .reset_n         (reset_n),
    .accept_i        (ext_accept),
    .sid_readdata_i  (sid_readdata),
    .readdata_o      (ext_readdata),
    .readdatavalid_o (ext_readdatavalid)
  );

  assign busy       = busy_q;
  assign check_done = done_q;
  assign check_pass = pass_q;
  assign id_word    = id_q;
  assign ts_word    = ts_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Scoreboard bench for sysid_check_ctrl: stimulus pushes expected responses, a negedge monitor pops and compares.
// Latency: expected cycle numbers are derived from the start sampling edge (done at +4, +3 per retry).
// Backpressure: external reads are held while ext_waitrequest is high.
module tb_sysid_check_ctrl;

  localparam logic [31:0] GOOD_ID = 32'hACD5_1302;
  localparam logic [31:0] GOOD_TS = 32'h54AC_5DC8;
  localparam logic [31:0] BAD_ID  = 32'hDEAD_BEEF;
  localparam logic [31:0] BAD_TS  = 32'h1234_5678;

  typedef struct {
    logic        pass;
    logic [3:0]  retry;
    logic [31:0] id;
    logic [31:0] ts;
    int          cyc;
  } chk_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } ext_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        ext_read;
  logic        ext_address;
  logic        ext_waitrequest;
  logic [31:0] ext_readdata;
  logic        ext_readdatavalid;
  logic        sid_address;
  logic [31:0] sid_readdata;
  logic        busy;
  logic        check_done;
  logic        check_pass;
  logic [31:0] id_word;
  logic [31:0] ts_word;
  logic [3:0]  retry_cnt;

  logic id_bad;
  logic ts_bad;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  chk_t chk_q[$];
  ext_t ext_q[$];
  chk_t e_chk;
  ext_t e_ext;
  logic done_prev = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Two-word slave model, combinational from sid_address.
  always_comb begin
    if (sid_address == 1'b0) sid_readdata = id_bad ? BAD_ID : GOOD_ID;
    else                     sid_readdata = ts_bad ? BAD_TS : GOOD_TS;
  end

  sysid_check_ctrl dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .start             (start),
    .ext_read          (ext_read),
    .ext_address       (ext_address),
    .ext_waitrequest   (ext_waitrequest),
    .ext_readdata      (ext_readdata),
    .ext_readdatavalid (ext_readdatavalid),
    .sid_address       (sid_address),
    .sid_readdata      (sid_readdata),
    .busy              (busy),
    .check_done        (check_done),
    .check_pass        (check_pass),
    .id_word           (id_word),
    .ts_word           (ts_word),
    .retry_cnt         (retry_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_chk(input logic pass, input logic [3:0] retry,
                          input logic [31:0] id, input logic [31:0] ts, input int at);
    chk_t c;
    c.pass = pass; c.retry = retry; c.id = id; c.ts = ts; c.cyc = at;
    chk_q.push_back(c);
  endtask

  task automatic push_ext(input logic [31:0] data, input int at);
    ext_t x;
    x.data = data; x.cyc = at;
    ext_q.push_back(x);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((ext_q.size() != 0 || chk_q.size() != 0) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_timeout", 32'(ext_q.size() + chk_q.size()), 32'd0);
    ext_q.delete();
    chk_q.delete();
  endtask

  task automatic check_reset_values();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_check_done", {31'd0, check_done}, 32'd0);
    check("rst_check_pass", {31'd0, check_pass}, 32'd0);
    check("rst_id_word", id_word, 32'd0);
    check("rst_ts_word", ts_word, 32'd0);
    check("rst_retry_cnt", {28'd0, retry_cnt}, 32'd0);
    check("rst_ext_readdata", ext_readdata, 32'd0);
    check("rst_ext_rdvalid", {31'd0, ext_readdatavalid}, 32'd0);
    check("rst_waitrequest", {31'd0, ext_waitrequest}, 32'd0);
    check("rst_sid_address", {31'd0, sid_address}, {31'd0, ext_address});
  endtask

  // Monitor: compares every response the DUT presents against the scoreboard.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (ext_readdatavalid) begin
        if (ext_q.size() == 0) begin
          check("ext_unexpected_valid", 32'd1, 32'd0);
        end else begin
          e_ext = ext_q.pop_front();
          check("ext_readdata", ext_readdata, e_ext.data);
          check("ext_latency", 32'(cyc), 32'(e_ext.cyc));
        end
      end
      if (check_done && !done_prev) begin
        if (chk_q.size() == 0) begin
          check("unexpected_check_done", 32'd1, 32'd0);
        end else begin
          e_chk = chk_q.pop_front();
          check("check_pass", {31'd0, check_pass}, {31'd0, e_chk.pass});
          check("retry_cnt", {28'd0, retry_cnt}, {28'd0, e_chk.retry});
          check("id_word", id_word, e_chk.id);
          check("ts_word", ts_word, e_chk.ts);
          check("done_cycle", 32'(cyc), 32'(e_chk.cyc));
        end
      end
    end
    done_prev = check_done;
  end

  initial begin
    int stalls;
    reset_n = 1'b0; start = 1'b0; ext_read = 1'b0; ext_address = 1'b0;
    id_bad = 1'b0; ts_bad = 1'b0;
    repeat (3) tick();

    // Reset state; sid_address must follow ext_address while idle.
    ext_read = 1'b1; ext_address = 1'b1;
    #1;
    check_reset_values();
    ext_read = 1'b0; ext_address = 1'b0;
    tick();

    // Auto-start: the first edge after release samples the start, done 4 edges later.
    push_chk(1'b1, 4'd0, GOOD_ID, GOOD_TS, cyc + 5);
    reset_n = 1'b1;
    wait_drain(30);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Back-to-back external reads: TS then ID, each 1 cycle after acceptance.
    ext_read = 1'b1; ext_address = 1'b1; push_ext(GOOD_TS, cyc + 1);
    tick();
    ext_address = 1'b0; push_ext(GOOD_ID, cyc + 1);
    tick();
    ext_read = 1'b0;
    wait_drain(10);

    // Bad ID on the first pass only: one retry, done at +7. A start during the check is dropped.
    id_bad = 1'b1;
    start = 1'b1; push_chk(1'b1, 4'd1, GOOD_ID, GOOD_TS, cyc + 1 + 7);
    tick();
    start = 1'b0;
    tick();
    tick();
    id_bad = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain(40);
    repeat (5) tick();
    check("busy_start_dropped", {31'd0, busy}, 32'd0);
    check("done_held", {31'd0, check_done}, 32'd1);

    // Permanently wrong timestamp: two retries then fail at +10.
    ts_bad = 1'b1;
    start = 1'b1; push_chk(1'b0, 4'd2, GOOD_ID, BAD_TS, cyc + 1 + 10);
    tick();
    start = 1'b0;
    wait_drain(60);
    ts_bad = 1'b0;
    tick();

    // start and ext_read together, then a read during RD_ID that stalls through CMP.
    start = 1'b1; ext_read = 1'b1; ext_address = 1'b0;
    push_ext(GOOD_ID, cyc + 1);
    push_chk(1'b1, 4'd0, GOOD_ID, GOOD_TS, cyc + 1 + 4);
    tick();
    start = 1'b0; ext_read = 1'b0;
    tick();
    ext_read = 1'b1; ext_address = 1'b1;
    stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!ext_waitrequest) break;
      stalls++;
      tick();
    end
    check("stall_cycles", 32'(stalls), 32'd3);
    push_ext(GOOD_TS, cyc + 1);
    tick();
    ext_read = 1'b0;
    wait_drain(20);

    // Reset asserted during RD_TS: immediate return to reset values, then a fresh auto check.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    ext_read = 1'b1; ext_address = 1'b0;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    ext_read = 1'b0;
    tick();
    tick();
    push_chk(1'b1, 4'd0, GOOD_ID, GOOD_TS, cyc + 5);
    reset_n = 1'b1;
    wait_drain(30);

    check("final_chk_queue", 32'(chk_q.size()), 32'd0);
    check("final_ext_queue", 32'(ext_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
